// File: rtl/dmem_pkg.sv
// Shared types and store-lane helpers for the byte-addressable data memory.
// Imported by dmem_load_align and dmem_ctrl.
package dmem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    localparam int MAX_LATENCY = 4;
    localparam int CNT_W       = 3;

    // Byte-enable pattern for a store of the given funct3 at the given byte offset.
    function automatic logic [3:0] store_strobe(input logic [2:0] size, input logic [1:0] offset);
        logic [3:0] strb;
        strb = 4'b0000;
        case (size)
            SZ_B:    strb = 4'b0001 << offset;
            SZ_H:    strb = offset[1] ? 4'b1100 : 4'b0011;
            SZ_W:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        lanes = wdata;
        case (size)
            SZ_B:    lanes = {4{wdata[7:0]}};
            SZ_H:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the load/store unit (master) and dmem_ctrl (slave).
interface dmem_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_load_align.sv
// Picks the byte/half/word out of a memory word and sign- or zero-extends it.
// Halfword selection looks only at offset[1], so an odd half offset naturally aligns down.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  size_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = 32'h0;
        case (size_i)
            SZ_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   data_o = {24'h0, byte_sel};
            SZ_H:    data_o = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   data_o = {16'h0, half_sel};
            SZ_W:    data_o = word_i;
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory with sub-word loads/stores and a fixed read latency.
// Optional macro DMEM_MISALIGN_FAULT_EN turns misaligned accesses into faults instead of aligning down.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [31:0]             mem [DEPTH];

    logic [2:0]              size;
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [1:0]              offset;
    logic                    illegal;
    logic                    fault;
    logic                    accept;
    logic                    wr_en;
    logic [3:0]              wstrb;
    logic [31:0]             wlanes;
    logic [31:0]             rd_word;
    logic [31:0]             ld_data;
    logic                    req_ready;
    logic                    resp_valid;

    always_comb begin
        size     = bus.req_size;
        word_idx = bus.req_addr[ADDR_WIDTH-1:2];
        offset   = bus.req_addr[1:0];
        case (size)
            SZ_B, SZ_H, SZ_W: illegal = 1'b0;
            SZ_BU, SZ_HU:     illegal = bus.req_we;
            default:          illegal = 1'b1;
        endcase
`ifdef DMEM_MISALIGN_FAULT_EN
        fault = illegal
              | ((size[1:0] == 2'b01) & offset[0])
              | ((size == SZ_W) & (offset != 2'b00));
`else
        // Misalignment needs no handling: halfword lanes use only offset[1], word lanes ignore the offset.
        fault = illegal;
`endif
        wstrb  = store_strobe(size, offset);
        wlanes = store_lanes(size, bus.req_wdata);
    end

    assign accept  = (state_q == IDLE) && bus.req_valid;
    assign wr_en   = accept && bus.req_we && !fault;
    assign rd_word = mem[word_idx];

    // Storage is deliberately not reset; stores commit on the acceptance edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    dmem_load_align u_load_align (
        .word_i   (rd_word),
        .offset_i (offset),
        .size_i   (size),
        .data_o   (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    err_d   = fault;
                    rdata_d = (!bus.req_we && !fault) ? ld_data : 32'h0;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench: drives the same request stream into LATENCY=1 and LATENCY=3 instances of dmem_ctrl.
// Expected responses are queued per instance and checked by a negedge monitor.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int AW = 12;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cycle;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [2:0]    req_size = 3'b000;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int cycle_cnt = 0;
    exp_t q1[$];
    exp_t q3[$];
    bit seen1 = 1'b0;
    bit seen3 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    dmem_if #(.ADDR_WIDTH(AW)) bus1 ();
    dmem_if #(.ADDR_WIDTH(AW)) bus3 ();

    assign bus1.req_valid  = req_valid;
    assign bus1.req_we     = req_we;
    assign bus1.req_size   = req_size;
    assign bus1.req_addr   = req_addr;
    assign bus1.req_wdata  = req_wdata;
    assign bus1.resp_ready = resp_ready;
    assign bus3.req_valid  = req_valid;
    assign bus3.req_we     = req_we;
    assign bus3.req_size   = req_size;
    assign bus3.req_addr   = req_addr;
    assign bus3.req_wdata  = req_wdata;
    assign bus3.resp_ready = resp_ready;

    dmem_ctrl #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    dmem_ctrl #(.ADDR_WIDTH(AW), .LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    task automatic cmp(input string tag, input int lat, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s L%0d: actual=%h required=%h", tag, lat, act, exp);
        end
    endtask

    task automatic checkOutput(input int lat, input logic valid, input logic rq_ready,
                               input logic [31:0] rdata, input logic err);
        exp_t e;
        int   qsize;
        bit   seen;
        if (!valid) return;
        qsize = (lat == 1) ? q1.size() : q3.size();
        if (qsize == 0) begin
            cmp("unexpected_resp", lat, 32'd1, 32'd0);
            return;
        end
        e    = (lat == 1) ? q1[0] : q3[0];
        seen = (lat == 1) ? seen1 : seen3;
        cmp({e.name, "_rdata"}, lat, rdata, e.rdata);
        cmp({e.name, "_err"}, lat, {31'h0, err}, {31'h0, e.err});
        cmp({e.name, "_req_ready_low"}, lat, {31'h0, rq_ready}, 32'h0);
        // First valid cycle sampled LATENCY-1 counter ticks after the acceptance edge.
        if (!seen) cmp({e.name, "_latency"}, lat, cycle_cnt - e.acc_cycle, lat - 1);
        if (lat == 1) seen1 = 1'b1; else seen3 = 1'b1;
        if (resp_ready) begin
            if (lat == 1) begin void'(q1.pop_front()); seen1 = 1'b0; end
            else          begin void'(q3.pop_front()); seen3 = 1'b0; end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput(1, bus1.resp_valid, bus1.req_ready, bus1.resp_rdata, bus1.resp_err);
            checkOutput(3, bus3.resp_valid, bus3.req_ready, bus3.resp_rdata, bus3.resp_err);
        end
    end

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = (q1.size() == 0) && (q3.size() == 0) && bus1.req_ready && bus3.req_ready;
        end
        if (!done) begin
            cmp("idle_timeout", 0, 32'd0, 32'd1);
            q1.delete();
            q3.delete();
            seen1 = 1'b0;
            seen3 = 1'b0;
        end
    endtask

    task automatic applyStimulus(input string name, input logic we, input logic [2:0] size,
                                 input logic [AW-1:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input bit expect_resp);
        exp_t e;
        waitIdle();
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        e.rdata     = exp_rdata;
        e.err       = exp_err;
        e.acc_cycle = cycle_cnt;
        e.name      = name;
        if (expect_resp) begin
            q1.push_back(e);
            q3.push_back(e);
        end
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_size  = 3'($urandom_range(0, 7));
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
    endtask

    task automatic load(input string name, input logic [2:0] size, input logic [AW-1:0] addr,
                        input logic [31:0] exp_rdata, input logic exp_err);
        applyStimulus(name, 1'b0, size, addr, 32'h0, exp_rdata, exp_err, 1'b1);
    endtask

    task automatic store(input string name, input logic [2:0] size, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic exp_err);
        applyStimulus(name, 1'b1, size, addr, wdata, 32'h0, exp_err, 1'b1);
    endtask

    task automatic checkResetOutputs(input string name);
        cmp({name, "_req_ready"}, 1, {31'h0, bus1.req_ready}, 32'd1);
        cmp({name, "_resp_valid"}, 1, {31'h0, bus1.resp_valid}, 32'd0);
        cmp({name, "_resp_rdata"}, 1, bus1.resp_rdata, 32'h0);
        cmp({name, "_resp_err"}, 1, {31'h0, bus1.resp_err}, 32'd0);
        cmp({name, "_req_ready"}, 3, {31'h0, bus3.req_ready}, 32'd1);
        cmp({name, "_resp_valid"}, 3, {31'h0, bus3.resp_valid}, 32'd0);
        cmp({name, "_resp_rdata"}, 3, bus3.resp_rdata, 32'h0);
        cmp({name, "_resp_err"}, 3, {31'h0, bus3.resp_err}, 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        store("sw_10", SZ_W, 12'h010, 32'hDEADBEEF, 1'b0);
        load ("lw_10", SZ_W, 12'h010, 32'hDEADBEEF, 1'b0);
        store("sb_13", SZ_B, 12'h013, 32'h00000080, 1'b0);
        load ("lb_13", SZ_B, 12'h013, 32'hFFFFFF80, 1'b0);
        load ("lbu_13", SZ_BU, 12'h013, 32'h00000080, 1'b0);
        load ("lw_10b", SZ_W, 12'h010, 32'h80ADBEEF, 1'b0);
        store("sh_12", SZ_H, 12'h012, 32'h00001234, 1'b0);
        load ("lh_12", SZ_H, 12'h012, 32'h00001234, 1'b0);
        load ("lhu_10", SZ_HU, 12'h010, 32'h0000BEEF, 1'b0);
        load ("lh_10", SZ_H, 12'h010, 32'hFFFFBEEF, 1'b0);

`ifdef DMEM_MISALIGN_FAULT_EN
        load ("lw_11_mis", SZ_W, 12'h011, 32'h0, 1'b1);
        store("sw_11_mis", SZ_W, 12'h011, 32'hFFFFFFFF, 1'b1);
        load ("lw_10_after_mis", SZ_W, 12'h010, 32'h1234BEEF, 1'b0);
        load ("lh_13_mis", SZ_H, 12'h013, 32'h0, 1'b1);
        load ("lhu_11_mis", SZ_HU, 12'h011, 32'h0, 1'b1);
`else
        load ("lw_11_align", SZ_W, 12'h011, 32'h1234BEEF, 1'b0);
        store("sw_11_align", SZ_W, 12'h011, 32'hFFFFFFFF, 1'b0);
        load ("lw_10_after_mis", SZ_W, 12'h010, 32'hFFFFFFFF, 1'b0);
        load ("lh_13_align", SZ_H, 12'h013, 32'hFFFFFFFF, 1'b0);
        load ("lhu_11_align", SZ_HU, 12'h011, 32'h0000FFFF, 1'b0);
`endif

        store("sw_14", SZ_W, 12'h014, 32'h00000000, 1'b0);
        store("sb_15", SZ_B, 12'h015, 32'hFFFFFF5A, 1'b0);
        load ("lw_14", SZ_W, 12'h014, 32'h00005A00, 1'b0);
        load ("lb_15", SZ_B, 12'h015, 32'h0000005A, 1'b0);
        load ("lh_16", SZ_H, 12'h016, 32'h00000000, 1'b0);
        load ("ill_ld_011", 3'b011, 12'h014, 32'h0, 1'b1);
        load ("ill_ld_111", 3'b111, 12'h014, 32'h0, 1'b1);
        store("ill_st_100", 3'b100, 12'h014, 32'hAAAAAAAA, 1'b1);
        store("ill_st_101", 3'b101, 12'h014, 32'hBBBBBBBB, 1'b1);
        load ("lw_14_after_ill", SZ_W, 12'h014, 32'h00005A00, 1'b0);

        // Backpressure: hold the response for several cycles, then release.
        waitIdle();
        resp_ready = 1'b0;
        load("lw_14_hold", SZ_W, 12'h014, 32'h00005A00, 1'b0);
        for (int i = 0; i < 20 && !bus3.resp_valid; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1;
        cmp("hold_release_req_ready", 1, {31'h0, bus1.req_ready}, 32'd1);
        cmp("hold_release_req_ready", 3, {31'h0, bus3.req_ready}, 32'd1);
        cmp("hold_release_valid", 3, {31'h0, bus3.resp_valid}, 32'd0);

        // Reset right after a store is accepted: store stays, response vanishes.
        applyStimulus("sw_20_reset", 1'b1, SZ_W, 12'h020, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1 checkResetOutputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load("lw_20_after_reset", SZ_W, 12'h020, 32'hCAFEF00D, 1'b0);
        load("lbu_22_after_reset", SZ_BU, 12'h022, 32'h000000FE, 1'b0);

        waitIdle();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        cmp("watchdog", 0, 32'd0, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Byte-addressable data memory with a valid/ready request/response interface, the next generation of the core's word-only memory. Supports RISC-V sub-word loads and stores (byte, halfword, word, with sign/zero extension) through per-byte write strobes, a parametrised read latency, and misaligned/illegal-size error reporting. It sits behind the core's load/store unit and serves one outstanding access at a time.

## Interface
- ADDR_WIDTH, 12: byte-address width. Depth is 2^(ADDR_WIDTH-2) 32-bit words.
- LATENCY, 1: cycles from request acceptance to resp_valid. Legal range 1..4.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  access faulted; no memory update occurred.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state IDLE.
- IDLE: req_ready=1. On req_valid, the request is accepted at the edge. If LATENCY=1, go to RESP; otherwise go to BUSY with the counter loaded to LATENCY-1.
- BUSY: req_ready=0. Decrement the counter each cycle. When it reaches 1, move to RESP on the next edge.
- RESP: resp_valid=1, and the response is held stable until resp_ready. On resp_valid && resp_ready, go to IDLE.
- Store commit: write the word at addr[ADDR_WIDTH-1:2] on the acceptance edge, using byte strobes:
  - SB: strobe = 1 << addr[1:0], with wdata[7:0] replicated into every byte lane.
  - SH: strobe = 0011 or 1100, selected by addr[1].
  - SW: strobe = 1111.
- Load: read the addressed word on the acceptance edge and register it. Select byte or half by addr[1:0]. Sign-extend for LB/LH; zero-extend for LBU/LHU.
- Errors:
  - Illegal req_size (011, 110, 111), and any size with req_we=1 other than 000/001/010, set resp_err=1.
  - An errored access produces no write and resp_rdata=0. It still follows the normal latency and handshake.
- Misalignment (halfword with addr[0]=1; word with addr[1:0]!=0) is handled per Configuration.
- Memory array is not reset. Contents after power-up are undefined to the bench, which must initialise before reading.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state IDLE, counter 0.
- A request accepted at edge T gives resp_valid=1 in the cycle after edge T+LATENCY-1 (LATENCY=1 means valid the cycle after acceptance).
- Minimum spacing between acceptances is LATENCY+1 cycles. A new request is never accepted in the same cycle as a response handshake.
- req_* may change freely while req_ready=0; the block ignores them.
- If resp_ready is already high when resp_valid rises, the response lasts exactly one cycle.
- Asynchronous reset mid-access returns the block to IDLE immediately and drops the pending response. A store already accepted stays committed.

## Configuration
- DMEM_MISALIGN_FAULT_EN defined: a misaligned access sets resp_err=1, performs no write and returns rdata=0.
- DMEM_MISALIGN_FAULT_EN undefined: misaligned addresses are silently aligned down (addr[0] cleared for halfword; addr[1:0] cleared for word). resp_err is set only for illegal sizes.

## Structure
- dmem_pkg holds:
  - the size_e enum (SZ_B=000, SZ_H=001, SZ_W=010, SZ_BU=100, SZ_HU=101);
  - the state_e enum (IDLE, BUSY, RESP);
  - the MAX_LATENCY=4 constant.
- One sub-module, dmem_load_align: combinational word + addr[1:0] + size to extended 32-bit result. It is shared with the store-strobe/lane generation function in the package.

## Test plan
- SW 0xDEADBEEF to 0x010, then LW 0x010 -> resp_rdata=0xDEADBEEF, resp_err=0, with resp_valid exactly LATENCY cycles after acceptance (run with LATENCY=1 and 3).
- SB 0x80 to 0x013, then LB 0x013 -> 0xFFFFFF80. LBU 0x013 -> 0x00000080. LW 0x010 -> 0x80ADBEEF.
- SH 0x1234 to 0x012, then LH 0x012 -> 0x00001234. LHU 0x010 -> 0x0000BEEF. LH 0x010 -> 0xFFFFBEEF.
- LW 0x011 with the macro defined -> resp_err=1, rdata=0. The same access without the macro -> the word at 0x010, err=0. SW to 0x011 with the macro defined -> memory unchanged.
- Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready=0. On release, one handshake, then req_ready=1 the next cycle.
- Assert rst_n=0 during BUSY after an accepted SW -> outputs go to reset values asynchronously and no response appears. A subsequent LW returns the stored value.
